// File: rtl/dmem_cache_pkg.sv
// rtl/dmem_cache_pkg.sv - shared sizes, address fields and FSM encoding for dmem_cache
package dmem_cache_pkg;
  localparam int WORD_SIZE   = 16;
  localparam int LINE_WORDS  = 4;
  localparam int NUM_LINES   = 4;
  localparam int LINE_BITS   = WORD_SIZE * LINE_WORDS;

  localparam int OFFSET_LSB  = 0;
  localparam int OFFSET_MSB  = 1;
  localparam int INDEX_LSB   = 2;
  localparam int INDEX_MSB   = 3;
  localparam int TAG_LSB     = 4;
  localparam int TAG_MSB     = 15;

  localparam int OFFSET_BITS = OFFSET_MSB - OFFSET_LSB + 1;
  localparam int INDEX_BITS  = INDEX_MSB - INDEX_LSB + 1;
  localparam int TAG_BITS    = TAG_MSB - TAG_LSB + 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;

  // Word 0 of a line sits in the least significant bits.
  function automatic logic [WORD_SIZE-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                     input logic [OFFSET_BITS-1:0] off);
    return line[off*WORD_SIZE +: WORD_SIZE];
  endfunction
endpackage

// File: rtl/dmem_cache_line_array.sv
// rtl/dmem_cache_line_array.sv - tag/valid/dirty/data storage with one combinational read port
module cache_line_array
  import dmem_cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_BITS-1:0]  i_rd_index,
  output logic                   o_rd_valid,
  output logic                   o_rd_dirty,
  output logic [TAG_BITS-1:0]    o_rd_tag,
  output logic [LINE_BITS-1:0]   o_rd_line,
  input  logic                   i_wr_en,
  input  logic                   i_wr_fill,
  input  logic [INDEX_BITS-1:0]  i_wr_index,
  input  logic [TAG_BITS-1:0]    i_wr_tag,
  input  logic [LINE_BITS-1:0]   i_wr_line,
  input  logic [OFFSET_BITS-1:0] i_wr_offset,
  input  logic [WORD_SIZE-1:0]   i_wr_word
);
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
  logic [LINE_BITS-1:0] r_data [NUM_LINES];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_dirty = r_dirty[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_data[i_rd_index];

  // Line state: a fill makes the line valid and clean, a word merge marks it dirty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wr_en) begin
      if (i_wr_fill) begin
        r_valid[i_wr_index] <= 1'b1;
        r_dirty[i_wr_index] <= 1'b0;
      end else begin
        r_dirty[i_wr_index] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset: every use is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (!reset && i_wr_en) begin
      if (i_wr_fill) begin
        r_tag[i_wr_index]  <= i_wr_tag;
        r_data[i_wr_index] <= i_wr_line;
      end else begin
        r_data[i_wr_index][i_wr_offset*WORD_SIZE +: WORD_SIZE] <= i_wr_word;
      end
    end
  end
endmodule

// File: rtl/dmem_cache.sv
// rtl/dmem_cache.sv - direct-mapped write-back write-allocate data cache
module dmem_cache
  import dmem_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [WORD_SIZE-1:0] cpu_address,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
);
  logic [1:0]           r_state;
  logic                 r_retry;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [WORD_SIZE-1:0] r_mem_address;
  logic [LINE_BITS-1:0] r_mem_wdata;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] r_hit_count;
  logic [WORD_SIZE-1:0] r_miss_count;

  logic [INDEX_BITS-1:0]  w_index;
  logic [OFFSET_BITS-1:0] w_offset;
  logic [TAG_BITS-1:0]    w_tag;
  logic                   w_req;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_rd_hit;
  logic                   w_merge;
  logic                   w_fill;
  logic                   w_line_valid;
  logic                   w_line_dirty;
  logic [TAG_BITS-1:0]    w_line_tag;
  logic [LINE_BITS-1:0]   w_line_data;
  logic [WORD_SIZE-1:0]   w_word;

  assign w_index  = cpu_address[INDEX_MSB:INDEX_LSB];
  assign w_offset = cpu_address[OFFSET_MSB:OFFSET_LSB];
  assign w_tag    = cpu_address[TAG_MSB:TAG_LSB];
  assign w_req    = cpu_read | cpu_write;

  // Lookup is only meaningful in IDLE; elsewhere the held request keeps stalling.
  assign w_hit    = (r_state == ST_IDLE) && w_line_valid && (w_line_tag == w_tag);
  assign w_miss   = w_req && (r_state == ST_IDLE) && !w_hit;
  assign w_rd_hit = cpu_read && w_hit;
  assign w_merge  = cpu_write && w_hit;
  assign w_fill   = (r_state == ST_ALLOCATE) && mem_ready;
  assign w_word   = line_word(w_line_data, w_offset);

  assign cpu_stall   = w_req && !w_hit;
  assign cpu_rdata   = w_rd_hit ? w_word : r_rdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

  cache_line_array u_lines (
    .clk         (clk),
    .reset       (reset),
    .i_rd_index  (w_index),
    .o_rd_valid  (w_line_valid),
    .o_rd_dirty  (w_line_dirty),
    .o_rd_tag    (w_line_tag),
    .o_rd_line   (w_line_data),
    .i_wr_en     (w_fill | w_merge),
    .i_wr_fill   (w_fill),
    .i_wr_index  (w_index),
    .i_wr_tag    (w_tag),
    .i_wr_line   (mem_rdata),
    .i_wr_offset (w_offset),
    .i_wr_word   (cpu_wdata)
  );

  // Miss handling: optional victim write-back, then line refill, with registered memory requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            if (w_line_valid && w_line_dirty) begin
              r_state       <= ST_WRITEBACK;
              r_mem_write   <= 1'b1;
              r_mem_address <= {w_line_tag, w_index, 2'b00};
              r_mem_wdata   <= w_line_data;
            end else begin
              r_state       <= ST_ALLOCATE;
              r_mem_read    <= 1'b1;
              r_mem_address <= {w_tag, w_index, 2'b00};
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready) begin
            r_state       <= ST_ALLOCATE;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b1;
            r_mem_address <= {w_tag, w_index, 2'b00};
          end
        end
        ST_ALLOCATE: begin
          if (mem_ready) begin
            r_state    <= ST_IDLE;
            r_mem_read <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Counters: the hit that completes a refilled access consumes the retry flag instead of counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retry      <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_miss) begin
      r_retry      <= 1'b1;
      r_miss_count <= r_miss_count + 1'b1;
    end else if (w_req && w_hit) begin
      if (r_retry) begin
        r_retry <= 1'b0;
      end else begin
        r_hit_count <= r_hit_count + 1'b1;
      end
    end
  end

  // Last load data is held so cpu_rdata stays stable between loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_rd_hit) begin
      r_rdata <= w_word;
    end
  end
endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipelined datapath's MEM-stage port and main memory.
- Consumes the datapath's read/write/address/data requests.
- Returns read data and a stall signal; the datapath freezes all pipeline registers while stall is high.
- Refills and write-backs whole lines over a line-wide memory handshake.
- Keeps hit and miss counters for performance reporting.

Parameters:
- WORD_SIZE, 16, data and address width.
- LINE_WORDS, 4, words per line; offset = address[1:0].
- NUM_LINES, 4, number of lines; index = address[3:2], tag = address[15:4].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_read  input  1  load request; held stable while cpu_stall=1.
- cpu_write  input  1  store request; held stable while cpu_stall=1.
- cpu_address  input  16  word address.
- cpu_wdata  input  16  store data.
- cpu_rdata  output  16  load data; valid in any cycle where cpu_read=1 and cpu_stall=0.
- cpu_stall  output  1  combinational; high while the request cannot complete this cycle.
- mem_read  output  1  line fetch request; level, held until mem_ready.
- mem_write  output  1  line write-back request; level, held until mem_ready.
- mem_address  output  16  line-aligned address (low 2 bits zero).
- mem_wdata  output  64  victim line, word0 in bits [15:0].
- mem_rdata  input  64  fetched line, same packing as mem_wdata.
- mem_ready  input  1  single-cycle completion pulse from memory.
- hit_count  output  16  number of accesses that hit.
- miss_count  output  16  number of accesses that missed.

Behaviour:
- Reset:
  - FSM goes to IDLE; all valid and dirty bits clear.
  - mem_read=0, mem_write=0, mem_address=0, cpu_rdata=0, hit_count=0, miss_count=0.
  - Reset during WRITEBACK or ALLOCATE abandons the transfer; the memory request drops on the edge where reset is sampled.
- Lookup (combinational, IDLE only): hit = valid[index] && tag[index]==cpu_address[15:4].
- cpu_stall = (cpu_read|cpu_write) && !(state==IDLE && hit).
- Read hit: cpu_rdata = line word[offset] in the same cycle; zero wait cycles.
- Write hit:
  - Word[offset] <= cpu_wdata and dirty <= 1 at the edge; no stall.
  - A read of the same word in the next cycle returns the new value.
- Both cpu_read and cpu_write high: treated as a write.
- No request: no state change; cpu_rdata holds its last value.
- FSM states:
  - IDLE: on a miss, miss_count++ and set the internal retry flag. Then go to WRITEBACK if the victim is valid&&dirty, else to ALLOCATE.
  - WRITEBACK: mem_write=1, mem_address={victim_tag,index,2'b00}, mem_wdata=victim line. On mem_ready, go to ALLOCATE.
  - ALLOCATE: mem_read=1, mem_address={req_tag,index,2'b00}. On mem_ready, write mem_rdata into the line, set tag, valid=1, dirty=0, and go to IDLE.
  - Back in IDLE the held request now hits and completes normally (a write applies its merge then).
- Counters:
  - The IDLE hit that completes a retried access does not increment hit_count; it clears the retry flag.
  - Every other IDLE hit increments hit_count.
  - Both counters wrap at 0xFFFF→0.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- Latency, with memory pulsing mem_ready in the L-th cycle of a request:
  - clean miss stalls L+1 cycles;
  - dirty miss stalls 2L+1 cycles.
- Changing cpu_address while stalled is a protocol violation; behaviour is undefined and checked by a bench assertion.

Decomposition:
- Shared package: WORD_SIZE, LINE_WORDS, NUM_LINES, TAG/INDEX/OFFSET bit ranges, FSM state encoding (IDLE, WRITEBACK, ALLOCATE).
- Sub-module cache_line_array holds the tag/valid/dirty/data storage.
  - Combinational read port.
  - One write port with modes: full-line fill, or single-word merge that sets dirty.
  - Synchronous clear of valid/dirty on reset.
- FSM, counters and memory interface live in dmem_cache.

Test Plan (memory model L=4, memory preloaded with mem[a]=a+0x1000):
- Reset, then read 0x0005 -> mem_read with mem_address=0x0004; cpu_stall high 5 cycles; cpu_rdata=0x1005; miss_count=1, hit_count=0.
- Read 0x0006 immediately after -> no stall, cpu_rdata=0x1006, hit_count=1.
- Write 0x0007=0xBEEF, then read 0x0007 -> no stall on either access; cpu_rdata=0xBEEF; hit_count=3.
- Read 0x0014 (index 1, tag 1, victim dirty) -> mem_write at 0x0004 with mem_wdata[63:48]=0xBEEF, then mem_read at 0x0014; stall 9 cycles; cpu_rdata=0x1014; miss_count=2.
- Write miss 0x0021=0x1234 -> allocate line 0x0020, merge the word; a following read of 0x0021 returns 0x1234 and of 0x0020 returns 0x1020; that line is dirty.
- Assert reset in the 2nd cycle of ALLOCATE for 0x0005 -> mem_read=0 next cycle, counters=0; a re-issued read of 0x0005 misses again with a full 5-cycle stall.
